// File: rtl/rv_pkg.sv
// Shared types and constants for the RV32I next-PC sequencer.
package rv_pkg;

   // Run/halt control state of the fetch sequencer
   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_HALT = 1'b1
   } state_t;

   // Sequential fetch increment (one 32-bit instruction)
   localparam logic [31:0] PC_INC = 32'd4;

   // Default fetch address driven while the core is held in reset
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage : rv_pkg

// File: rtl/hazard_detect.sv
// Load-use hazard comparator: flags an ID instruction that reads the
// destination of a load currently in EX. x0 never creates a hazard.
module hazard_detect (
   input  logic       i_ex_memread,
   input  logic [4:0] i_ex_rd,
   input  logic [4:0] i_id_rs1,
   input  logic [4:0] i_id_rs2,
   output logic       o_hazard
);

   logic w_rd_nonzero;
   logic w_src_match;

   assign w_rd_nonzero = (i_ex_rd != 5'd0);
   assign w_src_match  = (i_ex_rd == i_id_rs1) || (i_ex_rd == i_id_rs2);

   // Single hazard bit consumed by the sequencer priority mux
   always_comb begin
      o_hazard = i_ex_memread && w_rd_nonzero && w_src_match;
   end

endmodule : hazard_detect

// File: rtl/pc_seq_ctrl.sv
// Next-PC sequencer and pipeline hazard controller for the 5-stage core.
// Selects the next fetch address, drives PC / IF/ID / ID/EX stall and
// flush controls, tracks run/halt state and counts stalls and redirects.
module pc_seq_ctrl
   import rv_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
   parameter int          CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [31:0]      pc,
   input  logic             id_jump,
   input  logic [31:0]      id_target,
   input  logic             ex_redirect,
   input  logic [31:0]      ex_target,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic [4:0]       ex_rd,
   input  logic             ex_memread,
   input  logic             halt_req,
   input  logic [31:0]      halt_pc,
   input  logic             resume,
   output logic [31:0]      npc,
   output logic             pc_stall,
   output logic             ifid_stall,
   output logic             ifid_flush,
   output logic             idex_flush,
   output logic             halted,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   state_t           r_state;
   state_t           w_state_next;
   logic [CNT_W-1:0] r_stall_cnt;
   logic [CNT_W-1:0] r_flush_cnt;

   logic             w_hazard;
   logic [31:0]      w_npc;
   logic             w_pc_stall;
   logic             w_ifid_stall;
   logic             w_ifid_flush;
   logic             w_idex_flush;
   logic             w_stall_inc;
   logic             w_flush_inc;

   hazard_detect u_hazard_detect (
      .i_ex_memread (ex_memread),
      .i_ex_rd      (ex_rd),
      .i_id_rs1     (id_rs1),
      .i_id_rs2     (id_rs2),
      .o_hazard     (w_hazard)
   );

   // Priority mux for next PC and pipeline controls, plus FSM next state
   always_comb begin
      w_npc        = pc + PC_INC;
      w_pc_stall   = 1'b0;
      w_ifid_stall = 1'b0;
      w_ifid_flush = 1'b0;
      w_idex_flush = 1'b0;
      w_stall_inc  = 1'b0;
      w_flush_inc  = 1'b0;
      w_state_next = r_state;

      if (r_state == ST_HALT) begin
         // Freeze fetch and keep bubbling both stages; halt_req is ignored
         w_npc        = pc;
         w_pc_stall   = 1'b1;
         w_ifid_flush = 1'b1;
         w_idex_flush = 1'b1;
         if (resume) begin
            w_state_next = ST_RUN;
         end
      end else if (halt_req) begin
         // Resume point is the instruction after the ECALL/EBREAK
         w_npc        = halt_pc + PC_INC;
         w_ifid_flush = 1'b1;
         w_idex_flush = 1'b1;
         w_state_next = ST_HALT;
      end else if (ex_redirect) begin
         // Wins over load-use: the stalled ID instruction is wrong-path
         w_npc        = {ex_target[31:1], 1'b0};
         w_ifid_flush = 1'b1;
         w_idex_flush = 1'b1;
         w_flush_inc  = 1'b1;
      end else if (w_hazard) begin
         // Hold PC and IF/ID one cycle, insert a bubble into EX
         w_npc        = pc;
         w_pc_stall   = 1'b1;
         w_ifid_stall = 1'b1;
         w_idex_flush = 1'b1;
         w_stall_inc  = 1'b1;
      end else if (id_jump) begin
         w_npc        = {id_target[31:1], 1'b0};
         w_ifid_flush = 1'b1;
         w_flush_inc  = 1'b1;
      end
   end

   // Outputs are forced to their reset values while rst_n is low
   always_comb begin
      npc        = rst_n ? w_npc        : RESET_PC;
      pc_stall   = rst_n ? w_pc_stall   : 1'b0;
      ifid_stall = rst_n ? w_ifid_stall : 1'b0;
      ifid_flush = rst_n ? w_ifid_flush : 1'b0;
      idex_flush = rst_n ? w_idex_flush : 1'b0;
   end

   // Run/halt state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_RUN;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Saturating stall and redirect counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         if (w_stall_inc && (r_stall_cnt != CNT_MAX)) begin
            r_stall_cnt <= r_stall_cnt + CNT_ONE;
         end
         if (w_flush_inc && (r_flush_cnt != CNT_MAX)) begin
            r_flush_cnt <= r_flush_cnt + CNT_ONE;
         end
      end
   end

   assign halted    = (r_state == ST_HALT);
   assign stall_cnt = r_stall_cnt;
   assign flush_cnt = r_flush_cnt;

endmodule : pc_seq_ctrl

// File: doc/pc_seq_ctrl.md
# pc_seq_ctrl

Next-PC sequencer and pipeline hazard controller for the 5-stage RV32I core. It selects the next fetch address among sequential, ID-stage jump, EX-stage redirect and halt sources. It drives the stall input of the PC register and the stall/flush controls of the IF/ID and ID/EX pipeline registers. A two-state run/halt FSM and saturating stall/flush performance counters provide the sequential control.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, value driven on npc while in reset
- CNT_W, 16, width of performance counters

Ports:
- clk  in  1  core clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- pc  in  32  current PC from the PC register
- id_jump  in  1  JAL decoded in ID
- id_target  in  32  JAL target
- ex_redirect  in  1  taken branch or JALR resolved in EX
- ex_target  in  32  EX redirect target
- id_rs1, id_rs2  in  5  source registers of the instruction in ID
- ex_rd  in  5  destination of the instruction in EX
- ex_memread  in  1  instruction in EX is a load
- halt_req  in  1  ECALL/EBREAK reached EX
- halt_pc  in  32  PC of the halting instruction
- resume  in  1  leave HALT (debug/testbench)
- npc  out  32  next PC to PC register
- pc_stall  out  1  hold PC
- ifid_stall  out  1  hold IF/ID
- ifid_flush  out  1  bubble IF/ID
- idex_flush  out  1  bubble ID/EX
- halted  out  1  FSM in HALT
- stall_cnt  out  CNT_W  cycles with pc_stall=1 in RUN
- flush_cnt  out  CNT_W  redirect events (ex_redirect or id_jump taken)

## Operation
- FSM states: RUN, HALT. Reset → RUN.
- RUN, priority high→low, evaluated combinationally each cycle:
  1. halt_req: npc=halt_pc+4, pc_stall=0, ifid_flush=1, idex_flush=1; next state HALT.
  2. ex_redirect: npc={ex_target[31:1],1'b0}, ifid_flush=1, idex_flush=1; flush_cnt++.
  3. load-use: ex_memread && ex_rd!=0 && (ex_rd==id_rs1 || ex_rd==id_rs2): pc_stall=1, ifid_stall=1, idex_flush=1, npc=pc; stall_cnt++.
  4. id_jump: npc={id_target[31:1],1'b0}, ifid_flush=1; flush_cnt++.
  5. default: npc=pc+4 (mod 2^32), all controls 0.
- ex_redirect overrides a simultaneous load-use: the stalled ID instruction is on the wrong path and is flushed.
- HALT: pc_stall=1, ifid_flush=1, idex_flush=1, npc=pc, halted=1; counters frozen. resume → RUN next cycle; halt_req ignored in HALT.
- Counters saturate at all-ones and do not wrap.
- x0 never creates a load-use hazard.

## Timing
- All control outputs and npc are combinational from inputs and state, with zero latency; the PC register and pipeline registers sample them at the next rising edge.
- halted, state and counters are registered. halted rises the cycle after halt_req is sampled in RUN and falls the cycle after resume is sampled.
- Load-use stall lasts exactly one cycle when the load advances normally, because ex_memread drops once the load leaves EX.
- Reset (rst_n low, any time including mid-halt or mid-stall): state=RUN, halted=0, stall_cnt=0, flush_cnt=0, npc=RESET_PC, all stall/flush outputs 0. First edge after release runs default sequencing.
- resume and halt_req in the same cycle while in HALT: go to RUN, halt_req discarded.

## Structure
- Shared package rv_pkg: FSM state enum (RUN, HALT), PC_INC=32'd4, RESET_PC default.
- One natural sub-module: hazard_detect, the combinational load-use comparator producing a single hazard bit. Priority mux, FSM and counters stay in pc_seq_ctrl.

## Test plan
- Reset: hold rst_n=0 with pc=32'h40 → npc=0, all controls 0, counters 0. Release → npc=32'h44.
- Load-use: ex_memread=1, ex_rd=5, id_rs2=5, pc=32'h100 → pc_stall=ifid_stall=idex_flush=1, npc=32'h100, stall_cnt=1. With ex_rd=0 → no stall.
- Redirect with load-use: ex_redirect=1, ex_target=32'h201 plus a hazard → npc=32'h200, ifid_flush=idex_flush=1, pc_stall=0, flush_cnt+1, stall_cnt unchanged.
- Jump: id_jump=1, id_target=32'h80, pc=32'h10 → npc=32'h80, ifid_flush=1, idex_flush=0.
- Halt/resume: halt_req=1, halt_pc=32'h3C → npc=32'h40; halted=1 next cycle with pc_stall=1. Assert resume → halted=0 next cycle and npc=pc+4. Assert rst_n=0 during HALT → immediately RUN and halted=0.
- Saturation and wrap: force 2^16+3 load-use cycles → stall_cnt=16'hFFFF. pc=32'hFFFF_FFFC default → npc=0.
